// File: rtl/i2s_rx.sv
// I2S receiver: oversamples an external BCLK/WS/SD stream on clk,
// deserialises left/right slots (Philips framing, MSB first, left-justified)
// and presents each completed stereo frame on a valid/ready interface with
// sticky overrun and short-slot flags.
module i2s_rx #(
  parameter int SAMPLE_W = 16,
  parameter int CNT_W    = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i2s_bclk_in,
  input  logic                i2s_ws_in,
  input  logic                i2s_d_in,
  output logic [SAMPLE_W-1:0] sample_left_out,
  output logic [SAMPLE_W-1:0] sample_right_out,
  output logic                sample_valid_out,
  input  logic                sample_ready_in,
  output logic                overrun_out,
  output logic                short_slot_out,
  input  logic                err_clear_in
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // Counter value of the terminating bit of an exactly full slot.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SAMPLE_W - 1);

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Input capture
  // ---------------------------------------------------------------------
  // Bit 2 = bclk, bit 1 = ws, bit 0 = d.
  logic [2:0] pin_bus;
  logic [2:0] sync1_reg;
  logic [2:0] sync2_reg;

  assign pin_bus = {i2s_bclk_in, i2s_ws_in, i2s_d_in};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      // Two-flop synchroniser for each asynchronous pin.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_reg[gi] <= 1'b0;
          sync2_reg[gi] <= 1'b0;
        end else begin
          sync1_reg[gi] <= pin_bus[gi];
          sync2_reg[gi] <= sync1_reg[gi];
        end
      end
    end
  endgenerate

  logic bclk_d_reg;
  logic bedge_reg;
  logic ws_smp_reg;
  logic d_smp_reg;

  // Registered bclk rising-edge pulse, with ws/d sampled in the same cycle
  // so the three stay aligned downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_d_reg <= 1'b0;
      bedge_reg  <= 1'b0;
      ws_smp_reg <= 1'b0;
      d_smp_reg  <= 1'b0;
    end else begin
      bclk_d_reg <= sync2_reg[2];
      bedge_reg  <= sync2_reg[2] & ~bclk_d_reg;
      ws_smp_reg <= sync2_reg[1];
      d_smp_reg  <= sync2_reg[0];
    end
  end

  // ---------------------------------------------------------------------
  // Slot framing and bit capture
  // ---------------------------------------------------------------------
  logic                ws_prev_reg, ws_prev_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [SAMPLE_W-1:0] shift_reg, shift_next;
  logic [SAMPLE_W-1:0] bit_hit;
  logic [SAMPLE_W-1:0] captured;
  logic                slot_end;
  logic                slot_short;

  // Each bit lands directly at its final left-justified position, so a
  // slot that ends early leaves zeros in the missing LSBs for free. Bits
  // beyond SAMPLE_W match no position and are dropped.
  generate
    for (genvar gi = 0; gi < SAMPLE_W; gi++) begin : g_hit
      assign bit_hit[gi] = (cnt_reg == CNT_W'(SAMPLE_W - 1 - gi));
    end
  endgenerate

  assign captured   = shift_reg | (bit_hit & {SAMPLE_W{d_smp_reg}});
  assign slot_end   = bedge_reg && (ws_smp_reg != ws_prev_reg);
  // The terminating bit is counted, hence the comparison against LAST_IDX.
  assign slot_short = (cnt_reg < LAST_IDX);

  // Next values for the shift register, saturating bit counter and ws history.
  always_comb begin
    shift_next   = shift_reg;
    cnt_next     = cnt_reg;
    ws_prev_next = ws_prev_reg;
    if (bedge_reg) begin
      ws_prev_next = ws_smp_reg;
      if (slot_end) begin
        shift_next = '0;
        cnt_next   = '0;
      end else begin
        shift_next = captured;
        cnt_next   = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
      end
    end
  end

  // Slot datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg   <= '0;
      cnt_reg     <= '0;
      ws_prev_reg <= 1'b0;
    end else begin
      shift_reg   <= shift_next;
      cnt_reg     <= cnt_next;
      ws_prev_reg <= ws_prev_next;
    end
  end

  // ---------------------------------------------------------------------
  // Frame state machine
  // ---------------------------------------------------------------------
  state_t state_reg, state_next;
  logic   latch_left;
  logic   commit;
  logic   short_set;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_HUNT;
    else        state_reg <= state_next;
  end

  // Next state: only a right-slot end (ws 1->0) leaves HUNT, so capture
  // always starts on a left slot.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_HUNT:  if (slot_end && ws_prev_reg) state_next = ST_LEFT;
      ST_LEFT:  if (slot_end) state_next = ST_RIGHT;
      ST_RIGHT: if (slot_end) state_next = ST_LEFT;
      default:  state_next = ST_HUNT;
    endcase
  end

  // FSM outputs: latch left word, commit frame, flag a short slot.
  always_comb begin
    latch_left = 1'b0;
    commit     = 1'b0;
    short_set  = 1'b0;
    case (state_reg)
      ST_LEFT: begin
        latch_left = slot_end;
        short_set  = slot_end && slot_short;
      end
      ST_RIGHT: begin
        commit    = slot_end;
        short_set = slot_end && slot_short;
      end
      default: begin
        latch_left = 1'b0;
        commit     = 1'b0;
        short_set  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Output registers, handshake and sticky flags
  // ---------------------------------------------------------------------
  logic [SAMPLE_W-1:0] left_latch_reg;
  logic [SAMPLE_W-1:0] sample_left_reg;
  logic [SAMPLE_W-1:0] sample_right_reg;
  logic                valid_reg;
  logic                overrun_reg;
  logic                short_reg;

  // Hold the completed left word until the matching right slot ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          left_latch_reg <= '0;
    else if (latch_left) left_latch_reg <= captured;
  end

  // Frame output and valid; a commit always wins over a same-cycle accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_left_reg  <= '0;
      sample_right_reg <= '0;
      valid_reg        <= 1'b0;
    end else if (commit) begin
      sample_left_reg  <= left_latch_reg;
      sample_right_reg <= captured;
      valid_reg        <= 1'b1;
    end else if (valid_reg && sample_ready_in) begin
      valid_reg        <= 1'b0;
    end
  end

  // Sticky error flags; a set event beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_reg <= 1'b0;
      short_reg   <= 1'b0;
    end else begin
      if (commit && valid_reg && !sample_ready_in) overrun_reg <= 1'b1;
      else if (err_clear_in)                       overrun_reg <= 1'b0;
      if (short_set)         short_reg <= 1'b1;
      else if (err_clear_in) short_reg <= 1'b0;
    end
  end

  assign sample_left_out  = sample_left_reg;
  assign sample_right_out = sample_right_reg;
  assign sample_valid_out = valid_reg;
  assign overrun_out      = overrun_reg;
  assign short_slot_out   = short_reg;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: table of full-frame vectors plus hand-written
// sequences for overrun, hunt start-up and mid-frame reset.
module tb_i2s_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bclk = 1'b0;
  logic        ws = 1'b0;
  logic        d = 1'b0;
  logic        ready = 1'b1;
  logic        err_clear = 1'b0;
  logic [15:0] left_o;
  logic [15:0] right_o;
  logic        valid_o;
  logic        ovr_o;
  logic        short_o;

  int tests = 0;
  int fails = 0;

  logic [15:0] exp_l;
  logic [15:0] exp_r;

  typedef struct {
    int          bits;
    logic [31:0] l;
    logic [31:0] r;
    logic [15:0] el;
    logic [15:0] er;
    logic        es;
    logic        eo;
  } vec_t;

  vec_t vecs[4];

  i2s_rx #(.SAMPLE_W(16), .CNT_W(6)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i2s_bclk_in      (bclk),
    .i2s_ws_in        (ws),
    .i2s_d_in         (d),
    .sample_left_out  (left_o),
    .sample_right_out (right_o),
    .sample_valid_out (valid_o),
    .sample_ready_in  (ready),
    .overrun_out      (ovr_o),
    .short_slot_out   (short_o),
    .err_clear_in     (err_clear)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One bclk period of 8 clk: 3 low, 5 high. With chk set, verifies that
  // valid rises exactly 4 clk after the pin-level rising edge.
  task automatic send_bit(input logic w, input logic b, input bit chk);
    @(posedge clk); #1;
    bclk = 1'b0; ws = w; d = b;
    repeat (3) @(posedge clk);
    #1 bclk = 1'b1;
    repeat (3) @(posedge clk);
    if (chk) begin
      #1;
      check("latency_pre", {31'd0, valid_o}, 32'd0);
    end
    @(posedge clk);
    if (chk) begin
      #1;
      check("latency_valid", {31'd0, valid_o}, 32'd1);
      check("left", {16'd0, left_o}, {16'd0, exp_l});
      check("right", {16'd0, right_o}, {16'd0, exp_r});
    end
  endtask

  // Philips framing: ws flips to the next channel during this slot's LSB.
  task automatic send_slot(input logic ch, input int nbits, input logic [31:0] data, input bit chk);
    for (int i = nbits - 1; i >= 0; i--)
      send_bit((i == 0) ? ~ch : ch, data[i], chk && (i == 0));
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 err_clear = 1'b1;
    @(posedge clk); #1 err_clear = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, {31'd0, valid_o}, 32'd0);
    check({tag, "_left"}, {16'd0, left_o}, 32'd0);
    check({tag, "_right"}, {16'd0, right_o}, 32'd0);
    check({tag, "_overrun"}, {31'd0, ovr_o}, 32'd0);
    check({tag, "_short"}, {31'd0, short_o}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{16, 32'h0000A5C3, 32'h00001234, 16'hA5C3, 16'h1234, 1'b0, 1'b0};
    vecs[1] = '{16, 32'h00000001, 32'h0000FFFF, 16'h0001, 16'hFFFF, 1'b0, 1'b0};
    vecs[2] = '{32, 32'hDEADBEEF, 32'h01234567, 16'hDEAD, 16'h0123, 1'b0, 1'b0};
    vecs[3] = '{8,  32'h000000AB, 32'h000000CD, 16'hAB00, 16'hCD00, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Right-slot preamble takes the receiver out of HUNT
    send_slot(1'b1, 4, 32'h5, 1'b0);

    // Table-driven frames, ready held high
    for (int v = 0; v < 4; v++) begin
      exp_l = vecs[v].el;
      exp_r = vecs[v].er;
      send_slot(1'b0, vecs[v].bits, vecs[v].l, 1'b0);
      send_slot(1'b1, vecs[v].bits, vecs[v].r, 1'b1);
      check("short_flag", {31'd0, short_o}, {31'd0, vecs[v].es});
      check("overrun_flag", {31'd0, ovr_o}, {31'd0, vecs[v].eo});
      @(posedge clk); #1;
      check("valid_drop", {31'd0, valid_o}, 32'd0);
      $display("[TB] frame %0d: bits=%0d L=%h R=%h short=%0d", v, vecs[v].bits, left_o, right_o, short_o);
    end

    pulse_clear();
    check("short_cleared", {31'd0, short_o}, 32'd0);

    // Overrun: two frames with ready low
    ready = 1'b0;
    exp_l = 16'h1111;
    exp_r = 16'h2222;
    send_slot(1'b0, 16, 32'h1111, 1'b0);
    send_slot(1'b1, 16, 32'h2222, 1'b1);
    check("ovr_first_flag", {31'd0, ovr_o}, 32'd0);
    send_slot(1'b0, 16, 32'h3333, 1'b0);
    check("ovr_hold_left", {16'd0, left_o}, 32'h1111);
    check("ovr_hold_valid", {31'd0, valid_o}, 32'd1);
    send_slot(1'b1, 16, 32'h4444, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("ovr_left", {16'd0, left_o}, 32'h3333);
    check("ovr_right", {16'd0, right_o}, 32'h4444);
    check("ovr_valid", {31'd0, valid_o}, 32'd1);
    check("ovr_flag", {31'd0, ovr_o}, 32'd1);
    ready = 1'b1;
    @(posedge clk); #1;
    check("ovr_accept", {31'd0, valid_o}, 32'd0);
    check("ovr_sticky", {31'd0, ovr_o}, 32'd1);
    $display("[TB] overrun frame: L=%h R=%h overrun=%0d", left_o, right_o, ovr_o);
    pulse_clear();
    check("ovr_cleared", {31'd0, ovr_o}, 32'd0);

    // Start-up mid right slot: partial frame must not be reported
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    send_slot(1'b1, 6, 32'h2A, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("hunt_no_valid", {31'd0, valid_o}, 32'd0);
    check("hunt_no_short", {31'd0, short_o}, 32'd0);
    ready = 1'b0;
    exp_l = 16'h5A5A;
    exp_r = 16'h6B6B;
    send_slot(1'b0, 16, 32'h5A5A, 1'b0);
    send_slot(1'b1, 16, 32'h6B6B, 1'b1);
    check("hunt_short", {31'd0, short_o}, 32'd0);
    $display("[TB] hunt frame: L=%h R=%h", left_o, right_o);

    // Reset mid left slot: outputs clear at once, next full frame reported
    for (int i = 15; i >= 8; i--) send_bit(1'b0, 1'b1, 1'b0);
    check("prereset_valid", {31'd0, valid_o}, 32'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge clk); #1 rst_n = 1'b1;
    ready = 1'b1;
    for (int i = 7; i >= 0; i--) send_bit((i == 0) ? 1'b1 : 1'b0, 1'b0, 1'b0);
    send_slot(1'b1, 16, 32'hBEEF, 1'b0);
    exp_l = 16'h0F0F;
    exp_r = 16'hF0F0;
    send_slot(1'b0, 16, 32'h0F0F, 1'b0);
    send_slot(1'b1, 16, 32'hF0F0, 1'b1);
    @(posedge clk); #1;
    check("postreset_drop", {31'd0, valid_o}, 32'd0);
    check("postreset_short", {31'd0, short_o}, 32'd0);
    $display("[TB] post-reset frame: L=%h R=%h", left_o, right_o);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- Receive-side counterpart of the tone generator's I2S transmitter.
- Oversamples an external I2S stream (BCLK, WS, SD) on the system clock and deserialises left and right words into parallel samples.
- Presents each completed stereo frame on a ready/valid interface with sticky error flags.
- Used as an on-chip loopback/monitor and as the bench-side checker for the tone engine's audio output.

Parameters:
- SAMPLE_W, 16, captured bits per channel, MSB-first, left-justified in the slot.
- CNT_W, 6, slot bit-counter width; the counter saturates at 2^CNT_W-1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i2s_bclk_in  in  1  I2S bit clock, asynchronous, frequency <= clk/4.
- i2s_ws_in  in  1  word select; 0=left, 1=right.
- i2s_d_in  in  1  serial data.
- sample_left_out  out  SAMPLE_W  left sample of the last completed frame.
- sample_right_out  out  SAMPLE_W  right sample of the last completed frame.
- sample_valid_out  out  1  frame held in the output registers.
- sample_ready_in  in  1  consumer accepts the frame when high together with valid.
- overrun_out  out  1  sticky: a frame was overwritten before it was accepted.
- short_slot_out  out  1  sticky: a slot ended with fewer than SAMPLE_W bits.
- err_clear_in  in  1  single-cycle pulse clears both sticky flags.

Behaviour:
- Reset (async assert, sync release): all outputs 0; shift registers 0; bit counter 0; state HUNT.
- Input capture:
  - bclk, ws and d each pass through a 2-FF synchroniser.
  - A third bclk register detects the rising edge as a 1-cycle pulse (bedge).
  - ws and d are sampled only on bedge.
- Slot framing (Philips I2S):
  - ws_prev holds ws from the previous bedge.
  - On a bedge with ws != ws_prev, the current d bit is the LSB (last bit) of channel ws_prev, and that slot ends.
  - The next bedge carries the MSB of the new channel.
- Bit capture:
  - Bits with counter < SAMPLE_W shift into the channel shift register MSB-first.
  - Later bits are ignored; the counter still increments and saturates.
  - When a slot ends with count < SAMPLE_W, the captured bits are left-justified, the missing LSBs are 0, and short_slot_out is set.
  - Count includes the terminating bit.
- State machine:
  - HUNT: discard data. First WS 1->0 (slot end on a bedge) -> LEFT. A 0->1 change stays in HUNT, so capture always begins at a left slot.
  - LEFT: on left slot end -> latch left word, counter=0 -> RIGHT.
  - RIGHT: on right slot end -> commit frame -> LEFT.
  - The first partial slot after HUNT is never reported and never flags short_slot.
- Commit:
  - The output registers load the latched left word and the right word; sample_valid_out=1.
  - sample_valid_out rises exactly 4 clk cycles after the pin-level bclk rising edge that carries the right LSB (2 sync + 1 edge-detect + 1 commit).
- Handshake:
  - valid && ready in a cycle -> valid clears next cycle unless a commit occurs in the same cycle.
  - Commit while valid=1 and ready=0 -> data overwritten, valid stays 1, overrun_out set.
  - Commit in the same cycle as an accepted handshake -> new data loaded, valid stays 1, no overrun.
  - Output data is stable while valid=1 and no commit occurs.
- Errors:
  - err_clear_in clears both flags.
  - A set event in the same cycle as err_clear_in wins, and the flag is 1.
- WS glitch: a WS change detected in LEFT or RIGHT ends the slot as described; no resynchronisation to HUNT.
- Deasserting rst_n mid-frame discards the partial data and returns to HUNT.

Test Plan:
1. BCLK=clk/8, 16-bit slots, frames L=0xA5C3/R=0x1234 then L=0x0001/R=0xFFFF, ready=1 -> two valid pulses with exact values; valid rises 4 clk after the right-LSB bclk edge.
2. 32-bit slots, L=0xDEADBEEF, R=0x01234567 -> outputs 0xDEAD/0x0123; short_slot_out stays 0.
3. 8-bit slots, L=0xAB, R=0xCD -> outputs 0xAB00/0xCD00; short_slot_out=1. Pulse err_clear_in -> flag 0.
4. ready=0 across two frames (0x1111/0x2222, then 0x3333/0x4444) -> outputs 0x3333/0x4444, overrun_out=1, valid held. Raise ready -> valid drops the next cycle.
5. Stream starts mid-right-slot after reset -> that partial frame is not reported; the first reported frame is the first full L/R pair.
6. Assert rst_n low mid-left-slot -> all outputs 0 immediately; after release the next complete frame is reported correctly.
